ifu_dma_responder: RTL and testbench
====================================

# ifu_dma_responder

Responder-side counterpart of the IFU fetch controller; sits on the CU/AXI side of the arbiter. Serves the IFU's program-descriptor reads (program size, program start address) and accepts its three-word DMA request writes (size, source, destination). It acknowledges each complete request, then streams the requested words from program memory back to the IFU as a valid-qualified burst terminated by a done strobe.

## Interface
- DATA_WIDTH, 16, config/read-data word width
- ADDR_WIDTH, 16, config address and memory address width
- FIFO_WIDTH, 16, streamed data word width
- CFG_RD_BASE, 16'h0000, descriptor read base (prog_size at +0, prog_start at +2)
- CFG_WR_BASE, 16'h0010, request write base (size +0, source +2, dest +4)

- clk  in  1  clock
- rstn  in  1  reset; one clock, asynchronous, active-low
- host_start  in  1  latch host_prog_size/host_prog_addr, launch workload
- host_prog_size  in  DATA_WIDTH  program length in words
- host_prog_addr  in  ADDR_WIDTH  program start address
- ar2ifu_start_wl  out  1  one-cycle workload start pulse
- ifu2ar_rd_rqst, ifu2ar_wr_rqst, ifu2ar_addr_valid  in  1 each  IFU request qualifiers
- ifu2ar_addr  in  ADDR_WIDTH  request address
- ifu2ar_data_out  in  DATA_WIDTH  write data
- ar2ifu_data_in  out  DATA_WIDTH  read data
- ar2ifu_data_in_valid  out  1  read data valid
- ar2ifu_ack  out  1  request-accepted pulse
- ifu2ar_grant_rqst  in  1  IFU requests bus
- ar2ifu_grant  out  1  bus granted
- ifu2ar_stall  in  1  IFU FIFO near-full; pause issuing
- mem_rd_en  out  1  program memory read enable
- mem_addr  out  ADDR_WIDTH  memory address
- mem_rd_data  in  FIFO_WIDTH  memory data, valid cycle after mem_rd_en
- ar2ifu_wr_adata  out  FIFO_WIDTH  streamed word
- ar2ifu_wr_avalid  out  1  streamed word valid
- ar2ifu_wr_adone  out  1  last word of burst (coincident with its avalid)
- cfg_err  out  1  one-cycle pulse: zero-size request

## Operation
- All outputs registered; reset clears every output, descriptor and request register to 0, state IDLE.
- host_start (any state): prog_size/prog_start latched; ar2ifu_start_wl pulses next cycle.
- Descriptor reads, all states: cycle with rd_rqst&addr_valid → next cycle data_in_valid=1, data = prog_size (CFG_RD_BASE), prog_start (CFG_RD_BASE+2), else 0. Held request ⇒ valid every cycle.
- ar2ifu_grant <= ifu2ar_grant_rqst & (state != STREAM).
- States:
  - IDLE→CFG on first accepted request write.
  - CFG: write = wr_rqst&addr_valid; address selects size/src/dest register, sets its captured bit; other addresses ignored; rewriting a register overwrites. All three bits set → ACK.
  - ACK: ar2ifu_ack=1 one cycle; clear captured bits; load rd_ptr=src, issue_cnt=0, recv_cnt=0. Size≠0 → STREAM; size=0 → cfg_err pulse, IDLE.
  - STREAM: request writes ignored. Issue mem_rd_en, mem_addr=rd_ptr when issue_cnt<size and !ifu2ar_stall; rd_ptr+1 (wraps mod 2^ADDR_WIDTH), issue_cnt+1. Returned word registered onto wr_adata with avalid; recv_cnt+1; adone=1 on word recv_cnt==size-1. After last word → IDLE.
- Counters ADDR_WIDTH bits; size is word count (no byte scaling). Dest register stored, not used for streaming.

## Timing
- Read latency: request cycle t → data_in_valid at t+1.
- Write: third register captured at t → ack at t+1, first mem_rd_en at t+2, first avalid at t+4 (issue +1 memory, +1 output register).
- Stall is sampled at issue only; up to 2 words already in flight still delivered after stall asserts.
- Without stall: one word per cycle; size N burst occupies N consecutive avalid cycles, adone on the Nth, IDLE the following cycle.
- Simultaneous read and write request cycles both serviced.
- rstn low mid-burst: outputs cleared immediately (async), burst abandoned, no adone.

## Test plan
- Reset: assert rstn=0 mid-STREAM → all outputs 0 asynchronously, grant 0, state IDLE after release.
- Descriptor read: host_start size=100, addr=0x0400; read CFG_RD_BASE → 100 next cycle; CFG_RD_BASE+2 → 0x0400; addr 0x0006 → 0.
- Request: writes size=4, src=0x0400, dest=0xDEAD in order → ack 1 cycle after third; mem_addr 0x0400..0x0403; 4 avalid words matching memory; adone with 4th only.
- Stall: size=8, assert stall after 3rd issue for 5 cycles → ≤2 extra words delivered, issuing resumes at 0x0403 after release, total exactly 8 words, single adone.
- Zero size and writes out of order (dest, size, src) with one unknown-address write: out-of-order ack after third valid register; size=0 → ack, cfg_err pulse, no avalid, IDLE.
- Wrap: src=0xFFFE size=4 → mem_addr 0xFFFE, 0xFFFF, 0x0000, 0x0001.

Source files
------------

// File: rtl/ifu_dma_responder.sv
// ifu_dma_responder: answers IFU descriptor reads, collects its three-word
// DMA request, acknowledges it, then streams program-memory words back to
// the IFU as a valid-qualified burst closed by a done strobe.
module ifu_dma_responder #(
  parameter int unsigned           DATA_WIDTH  = 16,
  parameter int unsigned           ADDR_WIDTH  = 16,
  parameter int unsigned           FIFO_WIDTH  = 16,
  parameter logic [ADDR_WIDTH-1:0] CFG_RD_BASE = 16'h0000,
  parameter logic [ADDR_WIDTH-1:0] CFG_WR_BASE = 16'h0010
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  host_start,
  input  logic [DATA_WIDTH-1:0] host_prog_size,
  input  logic [ADDR_WIDTH-1:0] host_prog_addr,
  output logic                  ar2ifu_start_wl,
  input  logic                  ifu2ar_rd_rqst,
  input  logic                  ifu2ar_wr_rqst,
  input  logic                  ifu2ar_addr_valid,
  input  logic [ADDR_WIDTH-1:0] ifu2ar_addr,
  input  logic [DATA_WIDTH-1:0] ifu2ar_data_out,
  output logic [DATA_WIDTH-1:0] ar2ifu_data_in,
  output logic                  ar2ifu_data_in_valid,
  output logic                  ar2ifu_ack,
  input  logic                  ifu2ar_grant_rqst,
  output logic                  ar2ifu_grant,
  input  logic                  ifu2ar_stall,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [FIFO_WIDTH-1:0] mem_rd_data,
  output logic [FIFO_WIDTH-1:0] ar2ifu_wr_adata,
  output logic                  ar2ifu_wr_avalid,
  output logic                  ar2ifu_wr_adone,
  output logic                  cfg_err
);

  typedef enum logic [1:0] {IDLE, CFG, ACK, STREAM} state_t;

  localparam logic [ADDR_WIDTH-1:0] ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] OFS2 = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] OFS4 = ADDR_WIDTH'(4);

  localparam logic [ADDR_WIDTH-1:0] RD_SIZE_ADDR  = CFG_RD_BASE;
  localparam logic [ADDR_WIDTH-1:0] RD_START_ADDR = CFG_RD_BASE + OFS2;
  localparam logic [ADDR_WIDTH-1:0] WR_SIZE_ADDR  = CFG_WR_BASE;
  localparam logic [ADDR_WIDTH-1:0] WR_SRC_ADDR   = CFG_WR_BASE + OFS2;
  localparam logic [ADDR_WIDTH-1:0] WR_DEST_ADDR  = CFG_WR_BASE + OFS4;

  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] progSize_q;
  logic [ADDR_WIDTH-1:0] progStart_q;
  logic                  startWl_q;
  logic [DATA_WIDTH-1:0] rdData_q;
  logic                  rdValid_q;
  logic                  grant_q;

  logic [ADDR_WIDTH-1:0] size_q, size_d;
  logic [ADDR_WIDTH-1:0] src_q, src_d;
  logic [ADDR_WIDTH-1:0] dest_q, dest_d;
  logic [2:0]            have_q, have_d;

  logic [ADDR_WIDTH-1:0] rdPtr_q, rdPtr_d;
  logic [ADDR_WIDTH-1:0] issueCnt_q, issueCnt_d;
  logic [ADDR_WIDTH-1:0] recvCnt_q, recvCnt_d;
  logic                  memRdEn_q, memRdEn_d;
  logic [ADDR_WIDTH-1:0] memAddr_q, memAddr_d;
  logic                  memPend_q;

  logic [FIFO_WIDTH-1:0] wrData_q, wrData_d;
  logic                  wrValid_q, wrValid_d;
  logic                  wrDone_q, wrDone_d;
  logic                  ack_q, ack_d;
  logic                  cfgErr_q, cfgErr_d;

  logic wrAccept;
  logic capWr;

  assign wrAccept = ifu2ar_wr_rqst & ifu2ar_addr_valid;
  assign capWr    = wrAccept & ((state_q == IDLE) | (state_q == CFG));

  // Host descriptor latch, workload pulse, descriptor read port and grant.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      progSize_q  <= '0;
      progStart_q <= '0;
      startWl_q   <= 1'b0;
      rdData_q    <= '0;
      rdValid_q   <= 1'b0;
      grant_q     <= 1'b0;
    end else begin
      startWl_q <= host_start;
      if (host_start) begin
        progSize_q  <= host_prog_size;
        progStart_q <= host_prog_addr;
      end
      rdValid_q <= ifu2ar_rd_rqst & ifu2ar_addr_valid;
      if (ifu2ar_rd_rqst & ifu2ar_addr_valid) begin
        if (ifu2ar_addr == RD_SIZE_ADDR) begin
          rdData_q <= progSize_q;
        end else if (ifu2ar_addr == RD_START_ADDR) begin
          rdData_q <= DATA_WIDTH'(progStart_q);
        end else begin
          rdData_q <= '0;
        end
      end else begin
        rdData_q <= '0;
      end
      grant_q <= ifu2ar_grant_rqst & (state_q != STREAM);
    end
  end

  // Request FSM state and all request/stream datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      size_q     <= '0;
      src_q      <= '0;
      dest_q     <= '0;
      have_q     <= '0;
      rdPtr_q    <= '0;
      issueCnt_q <= '0;
      recvCnt_q  <= '0;
      memRdEn_q  <= 1'b0;
      memAddr_q  <= '0;
      memPend_q  <= 1'b0;
      wrData_q   <= '0;
      wrValid_q  <= 1'b0;
      wrDone_q   <= 1'b0;
      ack_q      <= 1'b0;
      cfgErr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      size_q     <= size_d;
      src_q      <= src_d;
      dest_q     <= dest_d;
      have_q     <= have_d;
      rdPtr_q    <= rdPtr_d;
      issueCnt_q <= issueCnt_d;
      recvCnt_q  <= recvCnt_d;
      memRdEn_q  <= memRdEn_d;
      memAddr_q  <= memAddr_d;
      memPend_q  <= memRdEn_q;
      wrData_q   <= wrData_d;
      wrValid_q  <= wrValid_d;
      wrDone_q   <= wrDone_d;
      ack_q      <= ack_d;
      cfgErr_q   <= cfgErr_d;
    end
  end

  // Next state: capture request words, acknowledge, then issue and collect
  // the burst. The first read is issued from the ACK cycle so memory sees
  // it one cycle after the acknowledge.
  always_comb begin
    state_d    = state_q;
    size_d     = size_q;
    src_d      = src_q;
    dest_d     = dest_q;
    have_d     = have_q;
    rdPtr_d    = rdPtr_q;
    issueCnt_d = issueCnt_q;
    recvCnt_d  = recvCnt_q;
    memRdEn_d  = 1'b0;
    memAddr_d  = memAddr_q;
    wrData_d   = wrData_q;
    wrValid_d  = 1'b0;
    wrDone_d   = 1'b0;
    ack_d      = 1'b0;
    cfgErr_d   = 1'b0;

    if (capWr) begin
      if (ifu2ar_addr == WR_SIZE_ADDR) begin
        size_d    = ADDR_WIDTH'(ifu2ar_data_out);
        have_d[0] = 1'b1;
      end else if (ifu2ar_addr == WR_SRC_ADDR) begin
        src_d     = ADDR_WIDTH'(ifu2ar_data_out);
        have_d[1] = 1'b1;
      end else if (ifu2ar_addr == WR_DEST_ADDR) begin
        dest_d    = ADDR_WIDTH'(ifu2ar_data_out);
        have_d[2] = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (capWr) begin
          state_d = CFG;
        end
      end
      CFG: begin
        if (&have_d) begin
          state_d = ACK;
          ack_d   = 1'b1;
        end
      end
      ACK: begin
        have_d     = '0;
        rdPtr_d    = src_q;
        issueCnt_d = '0;
        recvCnt_d  = '0;
        if (size_q == '0) begin
          cfgErr_d = 1'b1;
          state_d  = IDLE;
        end else begin
          state_d = STREAM;
          if (!ifu2ar_stall) begin
            memRdEn_d  = 1'b1;
            memAddr_d  = src_q;
            rdPtr_d    = src_q + ONE;
            issueCnt_d = ONE;
          end
        end
      end
      STREAM: begin
        if ((issueCnt_q < size_q) && !ifu2ar_stall) begin
          memRdEn_d  = 1'b1;
          memAddr_d  = rdPtr_q;
          rdPtr_d    = rdPtr_q + ONE;
          issueCnt_d = issueCnt_q + ONE;
        end
        if (memPend_q) begin
          wrData_d  = mem_rd_data;
          wrValid_d = 1'b1;
          wrDone_d  = (recvCnt_q == (size_q - ONE));
          recvCnt_d = recvCnt_q + ONE;
        end
        if (wrDone_q) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ar2ifu_start_wl      = startWl_q;
  assign ar2ifu_data_in       = rdData_q;
  assign ar2ifu_data_in_valid = rdValid_q;
  assign ar2ifu_ack           = ack_q;
  assign ar2ifu_grant         = grant_q;
  assign mem_rd_en            = memRdEn_q;
  assign mem_addr             = memAddr_q;
  assign ar2ifu_wr_adata      = wrData_q;
  assign ar2ifu_wr_avalid     = wrValid_q;
  assign ar2ifu_wr_adone      = wrDone_q;
  assign cfg_err              = cfgErr_q;

endmodule

// File: tb/tb_ifu_dma_responder.sv
// tb_ifu_dma_responder: directed bench for ifu_dma_responder with a simple
// one-cycle-latency program memory model.
module tb_ifu_dma_responder;

  logic        clk;
  logic        rstn;
  logic        host_start;
  logic [15:0] host_prog_size;
  logic [15:0] host_prog_addr;
  logic        ar2ifu_start_wl;
  logic        ifu2ar_rd_rqst;
  logic        ifu2ar_wr_rqst;
  logic        ifu2ar_addr_valid;
  logic [15:0] ifu2ar_addr;
  logic [15:0] ifu2ar_data_out;
  logic [15:0] ar2ifu_data_in;
  logic        ar2ifu_data_in_valid;
  logic        ar2ifu_ack;
  logic        ifu2ar_grant_rqst;
  logic        ar2ifu_grant;
  logic        ifu2ar_stall;
  logic        mem_rd_en;
  logic [15:0] mem_addr;
  logic [15:0] mem_rd_data;
  logic [15:0] ar2ifu_wr_adata;
  logic        ar2ifu_wr_avalid;
  logic        ar2ifu_wr_adone;
  logic        cfg_err;

  int assertCount = 0;
  int failCount   = 0;

  logic [15:0] issuedAddr[$];
  logic [15:0] gotData[$];
  int          doneCount = 0;
  int          doneIdx   = 0;

  ifu_dma_responder dut (
    .clk                  (clk),
    .rstn                 (rstn),
    .host_start           (host_start),
    .host_prog_size       (host_prog_size),
    .host_prog_addr       (host_prog_addr),
    .ar2ifu_start_wl      (ar2ifu_start_wl),
    .ifu2ar_rd_rqst       (ifu2ar_rd_rqst),
    .ifu2ar_wr_rqst       (ifu2ar_wr_rqst),
    .ifu2ar_addr_valid    (ifu2ar_addr_valid),
    .ifu2ar_addr          (ifu2ar_addr),
    .ifu2ar_data_out      (ifu2ar_data_out),
    .ar2ifu_data_in       (ar2ifu_data_in),
    .ar2ifu_data_in_valid (ar2ifu_data_in_valid),
    .ar2ifu_ack           (ar2ifu_ack),
    .ifu2ar_grant_rqst    (ifu2ar_grant_rqst),
    .ar2ifu_grant         (ar2ifu_grant),
    .ifu2ar_stall         (ifu2ar_stall),
    .mem_rd_en            (mem_rd_en),
    .mem_addr             (mem_addr),
    .mem_rd_data          (mem_rd_data),
    .ar2ifu_wr_adata      (ar2ifu_wr_adata),
    .ar2ifu_wr_avalid     (ar2ifu_wr_avalid),
    .ar2ifu_wr_adone      (ar2ifu_wr_adone),
    .cfg_err              (cfg_err)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Program memory contents as a fixed function of address.
  function automatic logic [15:0] memWord(input logic [15:0] a);
    return a ^ 16'h5A3C;
  endfunction

  // Memory model: data appears the cycle after a read enable.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= memWord(mem_addr);
  end

  // Record issued addresses and streamed words shortly after each edge.
  always @(posedge clk) begin
    #2;
    if (rstn) begin
      if (mem_rd_en) issuedAddr.push_back(mem_addr);
      if (ar2ifu_wr_avalid) begin
        gotData.push_back(ar2ifu_wr_adata);
        if (ar2ifu_wr_adone) begin
          doneCount++;
          doneIdx = gotData.size();
        end
      end
    end
  end

  // Hard stop in case something never finishes.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h required 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    ifu2ar_wr_rqst    = 1'b1;
    ifu2ar_addr_valid = 1'b1;
    ifu2ar_addr       = a;
    ifu2ar_data_out   = d;
    @(negedge clk);
    ifu2ar_wr_rqst    = 1'b0;
    ifu2ar_addr_valid = 1'b0;
  endtask

  task automatic descRead(input logic [15:0] a, input logic [15:0] exp, input string tag);
    @(negedge clk);
    ifu2ar_rd_rqst    = 1'b1;
    ifu2ar_addr_valid = 1'b1;
    ifu2ar_addr       = a;
    @(negedge clk);
    checkOutput({tag, "_valid"}, 32'(ar2ifu_data_in_valid), 32'd1);
    checkOutput({tag, "_data"}, 32'(ar2ifu_data_in), 32'(exp));
    ifu2ar_rd_rqst    = 1'b0;
    ifu2ar_addr_valid = 1'b0;
  endtask

  task automatic waitDone(input int target, input int budget, input string tag);
    for (int i = 0; i < budget && doneCount < target; i++) @(negedge clk);
    checkOutput({tag, "_doneInTime"}, 32'(doneCount >= target), 32'd1);
  endtask

  task automatic clearLog();
    issuedAddr.delete();
    gotData.delete();
    doneCount = 0;
    doneIdx   = 0;
  endtask

  task automatic checkBurst(input string tag, input logic [15:0] base, input int n);
    logic [15:0] a;
    checkOutput({tag, "_issued"}, 32'(issuedAddr.size()), 32'(n));
    checkOutput({tag, "_words"}, 32'(gotData.size()), 32'(n));
    checkOutput({tag, "_doneCount"}, 32'(doneCount), 32'd1);
    checkOutput({tag, "_doneIdx"}, 32'(doneIdx), 32'(n));
    for (int i = 0; i < n && i < issuedAddr.size() && i < gotData.size(); i++) begin
      a = base + 16'(i);
      checkOutput($sformatf("%s_addr%0d", tag, i), 32'(issuedAddr[i]), 32'(a));
      checkOutput($sformatf("%s_data%0d", tag, i), 32'(gotData[i]), 32'(memWord(a)));
    end
  endtask

  initial begin
    int n;
    int extra;
    int stallIssues;
    int gs;

    rstn              = 1'b0;
    host_start        = 1'b0;
    host_prog_size    = '0;
    host_prog_addr    = '0;
    ifu2ar_rd_rqst    = 1'b0;
    ifu2ar_wr_rqst    = 1'b0;
    ifu2ar_addr_valid = 1'b0;
    ifu2ar_addr       = '0;
    ifu2ar_data_out   = '0;
    ifu2ar_grant_rqst = 1'b0;
    ifu2ar_stall      = 1'b0;
    mem_rd_data       = '0;

    // Reset state
    #1;
    checkOutput("rst_startWl", 32'(ar2ifu_start_wl), 32'd0);
    checkOutput("rst_ack", 32'(ar2ifu_ack), 32'd0);
    checkOutput("rst_memRdEn", 32'(mem_rd_en), 32'd0);
    checkOutput("rst_avalid", 32'(ar2ifu_wr_avalid), 32'd0);
    checkOutput("rst_cfgErr", 32'(cfg_err), 32'd0);
    repeat (3) @(negedge clk);
    rstn              = 1'b1;
    ifu2ar_grant_rqst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("idle_grant", 32'(ar2ifu_grant), 32'd1);

    // Host start and descriptor reads
    @(negedge clk);
    host_start     = 1'b1;
    host_prog_size = 16'd100;
    host_prog_addr = 16'h0400;
    @(negedge clk);
    host_start = 1'b0;
    checkOutput("startWl_pulse", 32'(ar2ifu_start_wl), 32'd1);
    @(negedge clk);
    checkOutput("startWl_clear", 32'(ar2ifu_start_wl), 32'd0);
    descRead(16'h0000, 16'd100, "rdSize");
    descRead(16'h0002, 16'h0400, "rdStart");
    descRead(16'h0006, 16'h0000, "rdOther");
    @(negedge clk);
    checkOutput("rd_validDrop", 32'(ar2ifu_data_in_valid), 32'd0);

    // Basic request: size 4 from 0x0400
    clearLog();
    applyStimulus(16'h0010, 16'd4);
    applyStimulus(16'h0012, 16'h0400);
    checkOutput("b1_noAckEarly", 32'(ar2ifu_ack), 32'd0);
    applyStimulus(16'h0014, 16'hDEAD);
    checkOutput("b1_ack", 32'(ar2ifu_ack), 32'd1);
    @(negedge clk);
    checkOutput("b1_ackPulse", 32'(ar2ifu_ack), 32'd0);
    checkOutput("b1_firstRdEn", 32'(mem_rd_en), 32'd1);
    checkOutput("b1_firstAddr", 32'(mem_addr), 32'h0400);
    @(negedge clk);
    checkOutput("b1_grantStream", 32'(ar2ifu_grant), 32'd0);
    checkOutput("b1_noAvalidYet", 32'(ar2ifu_wr_avalid), 32'd0);
    @(negedge clk);
    checkOutput("b1_firstAvalid", 32'(ar2ifu_wr_avalid), 32'd1);
    checkOutput("b1_firstData", 32'(ar2ifu_wr_adata), 32'(memWord(16'h0400)));
    checkOutput("b1_firstNotDone", 32'(ar2ifu_wr_adone), 32'd0);
    waitDone(1, 50, "b1");
    repeat (2) @(negedge clk);
    checkOutput("b1_grantBack", 32'(ar2ifu_grant), 32'd1);
    checkBurst("b1", 16'h0400, 4);

    // Stall after the third issue, held for five cycles
    clearLog();
    applyStimulus(16'h0010, 16'd8);
    applyStimulus(16'h0012, 16'h0400);
    applyStimulus(16'h0014, 16'h0000);
    n = 0;
    for (int i = 0; i < 40 && n < 3; i++) begin
      @(negedge clk);
      if (mem_rd_en) n++;
    end
    checkOutput("st_reachedThird", 32'(n), 32'd3);
    ifu2ar_stall = 1'b1;
    extra        = 0;
    stallIssues  = 0;
    repeat (5) begin
      @(negedge clk);
      if (mem_rd_en) stallIssues++;
      if (ar2ifu_wr_avalid) extra++;
    end
    ifu2ar_stall = 1'b0;
    checkOutput("st_noIssueStalled", 32'(stallIssues), 32'd0);
    checkOutput("st_inFlightLe2", 32'(extra <= 2), 32'd1);
    checkOutput("st_issuedBefore", 32'(issuedAddr.size()), 32'd3);
    waitDone(1, 60, "st");
    checkBurst("st", 16'h0400, 8);

    // Out-of-order writes with an unknown address, zero size
    clearLog();
    applyStimulus(16'h0014, 16'h1234);
    checkOutput("z_noAck1", 32'(ar2ifu_ack), 32'd0);
    applyStimulus(16'h0010, 16'h0000);
    checkOutput("z_noAck2", 32'(ar2ifu_ack), 32'd0);
    applyStimulus(16'h001A, 16'h5555);
    checkOutput("z_noAckUnknown", 32'(ar2ifu_ack), 32'd0);
    applyStimulus(16'h0012, 16'h0100);
    checkOutput("z_ack", 32'(ar2ifu_ack), 32'd1);
    checkOutput("z_noErrYet", 32'(cfg_err), 32'd0);
    @(negedge clk);
    checkOutput("z_ackPulse", 32'(ar2ifu_ack), 32'd0);
    checkOutput("z_cfgErr", 32'(cfg_err), 32'd1);
    @(negedge clk);
    checkOutput("z_cfgErrPulse", 32'(cfg_err), 32'd0);
    checkOutput("z_grantIdle", 32'(ar2ifu_grant), 32'd1);
    repeat (5) @(negedge clk);
    checkOutput("z_noWords", 32'(gotData.size()), 32'd0);
    checkOutput("z_noIssue", 32'(issuedAddr.size()), 32'd0);

    // Address wrap
    clearLog();
    applyStimulus(16'h0010, 16'd4);
    applyStimulus(16'h0012, 16'hFFFE);
    applyStimulus(16'h0014, 16'h0000);
    waitDone(1, 50, "wr");
    checkBurst("wr", 16'hFFFE, 4);

    // Reset in the middle of a burst
    clearLog();
    applyStimulus(16'h0010, 16'd8);
    applyStimulus(16'h0012, 16'h0200);
    applyStimulus(16'h0014, 16'h0000);
    for (int i = 0; i < 40 && gotData.size() < 2; i++) @(negedge clk);
    checkOutput("mr_midBurst", 32'(gotData.size() >= 2), 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("mr_memRdEn", 32'(mem_rd_en), 32'd0);
    checkOutput("mr_avalid", 32'(ar2ifu_wr_avalid), 32'd0);
    checkOutput("mr_adone", 32'(ar2ifu_wr_adone), 32'd0);
    checkOutput("mr_grant", 32'(ar2ifu_grant), 32'd0);
    checkOutput("mr_adata", 32'(ar2ifu_wr_adata), 32'd0);
    checkOutput("mr_memAddr", 32'(mem_addr), 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    gs   = gotData.size();
    repeat (10) @(negedge clk);
    checkOutput("mr_noMoreWords", 32'(gotData.size()), 32'(gs));
    checkOutput("mr_noDone", 32'(doneCount), 32'd0);
    checkOutput("mr_grantIdle", 32'(ar2ifu_grant), 32'd1);
    checkOutput("mr_noIssue", 32'(mem_rd_en), 32'd0);
    descRead(16'h0000, 16'h0000, "mr_sizeCleared");

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
